// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register numbers, exception codes,
// field positions and default addresses.
package cp0_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;

    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    localparam int SR_IM_HI   = 15;
    localparam int SR_IM_LO   = 10;
    localparam int SR_EXL     = 1;
    localparam int SR_IE      = 0;
    localparam int CAUSE_BD   = 31;
    localparam int CAUSE_IP_HI = 15;
    localparam int CAUSE_IP_LO = 10;
    localparam int CAUSE_EC_HI = 6;
    localparam int CAUSE_EC_LO = 2;

    localparam logic [31:0] SR_MASK = 32'h0000_fc03;

    localparam logic [31:0] HANDLER_PC_DEF   = 32'h0000_4180;
    localparam logic [31:0] INT_ACK_ADDR_DEF = 32'h0000_7f20;

    // Delay-slot victims restart at the branch, one word back.
    function automatic logic [31:0] epc_target(
        input logic [31:0] pc,
        input logic        bd
    );
        logic [31:0] aligned;
        aligned = pc & ~32'h3;
        return bd ? aligned - 32'd4 : aligned;
    endfunction

endpackage

// File: rtl/cp0_if.sv
// M-stage <-> CP0 signal bundle.
// master = pipeline side, slave = CP0 side.
interface cp0_if;

    logic        en;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_in;
    logic [31:0] cp0_out;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        exl_clr;
    logic        req;
    logic [31:0] epc_out;
    logic [31:0] handler_pc;

    modport master (
        output en,
        output cp0_addr,
        output cp0_in,
        output vpc,
        output bd_in,
        output exc_code_in,
        output hw_int,
        output exl_clr,
        input  cp0_out,
        input  req,
        input  epc_out,
        input  handler_pc
    );

    modport slave (
        input  en,
        input  cp0_addr,
        input  cp0_in,
        input  vpc,
        input  bd_in,
        input  exc_code_in,
        input  hw_int,
        input  exl_clr,
        output cp0_out,
        output req,
        output epc_out,
        output handler_pc
    );

endinterface

// File: rtl/cp0.sv
// Coprocessor 0: SR/Cause/EPC and the M-stage exception/interrupt
// request decision.
module cp0
    import cp0_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC   = HANDLER_PC_DEF,
    parameter logic [31:0] INT_ACK_ADDR = INT_ACK_ADDR_DEF
) (
    input logic   clk,
    input logic   reset,
    cp0_if.slave  bus
);

    logic [31:0] sr_q, sr_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;

    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        int_req;
    logic        exc_req;
    logic        req;
    logic        wr_sr;
    logic        wr_epc;
    logic [31:0] rd_data;
    logic        unused_ack;

    // The ack address is consumed by the bus side, not by CP0 itself.
    assign unused_ack = ^INT_ACK_ADDR;

    assign im  = sr_q[SR_IM_HI:SR_IM_LO];
    assign exl = sr_q[SR_EXL];
    assign ie  = sr_q[SR_IE];

    assign int_req = (|(bus.hw_int & im)) & ie & ~exl;
    assign exc_req = (bus.exc_code_in != 5'd0) & ~exl;
    assign req     = int_req | exc_req;

    assign wr_sr  = bus.en && (bus.cp0_addr == REG_SR);
    assign wr_epc = bus.en && (bus.cp0_addr == REG_EPC);

    always_comb begin
        sr_d    = sr_q;
        cause_d = cause_q;
        epc_d   = epc_q;

        cause_d[CAUSE_IP_HI:CAUSE_IP_LO] = bus.hw_int;

        if (req) begin
            sr_d[SR_EXL]    = 1'b1;
            cause_d[CAUSE_BD] = bus.bd_in;
            cause_d[CAUSE_EC_HI:CAUSE_EC_LO] =
                int_req ? EXC_INT : bus.exc_code_in;
            epc_d = epc_target(bus.vpc, bus.bd_in);
        end else begin
            if (wr_sr) begin
                sr_d = bus.cp0_in & SR_MASK;
            end
            if (wr_epc) begin
                epc_d = bus.cp0_in;
            end
            // eret wins over an mtc0 SR.EXL=1 in the same cycle.
            if (bus.exl_clr) begin
                sr_d[SR_EXL] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q    <= '0;
            cause_q <= '0;
            epc_q   <= '0;
        end else begin
            sr_q    <= sr_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
        end
    end

    always_comb begin
        rd_data = '0;
        case (bus.cp0_addr)
            REG_SR:    rd_data = sr_q;
            REG_CAUSE: rd_data = cause_q;
            REG_EPC:   rd_data = epc_q;
            default:   rd_data = '0;
        endcase
    end

    assign bus.cp0_out    = rd_data;
    assign bus.req        = req;
    assign bus.epc_out    = epc_q;
    assign bus.handler_pc = HANDLER_PC;

endmodule

// File: tb/tb_cp0.sv
// Self-checking bench for cp0: directed scenarios plus randomized
// traffic checked against a field-level behavioural model.
module tb_cp0;

    logic clk = 1'b0;
    logic reset;
    logic chk_on = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    cp0_if bus();

    cp0 u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: register fields kept separately.
    logic [5:0]  m_im = '0;
    logic        m_exl = 1'b0;
    logic        m_ie = 1'b0;
    logic        m_bd = 1'b0;
    logic [5:0]  m_ip = '0;
    logic [4:0]  m_code = '0;
    logic [31:0] m_epc = '0;

    function automatic logic m_int();
        return ((bus.hw_int & m_im) != 6'd0) && m_ie && !m_exl;
    endfunction

    function automatic logic m_take();
        return m_int() || ((bus.exc_code_in != 5'd0) && !m_exl);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12: return {16'd0, m_im, 8'd0, m_exl, m_ie};
            5'd13: return {m_bd, 15'd0, m_ip, 3'd0, m_code, 2'd0};
            5'd14: return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_im <= '0; m_exl <= 1'b0; m_ie <= 1'b0;
            m_bd <= 1'b0; m_ip <= '0; m_code <= '0; m_epc <= '0;
        end else begin
            m_ip <= bus.hw_int;
            if (m_take()) begin
                m_exl  <= 1'b1;
                m_bd   <= bus.bd_in;
                m_code <= m_int() ? 5'd0 : bus.exc_code_in;
                m_epc  <= (bus.vpc & 32'hffff_fffc)
                          - (bus.bd_in ? 32'd4 : 32'd0);
            end else begin
                if (bus.en && bus.cp0_addr == 5'd12) begin
                    m_im  <= bus.cp0_in[15:10];
                    m_exl <= bus.cp0_in[1];
                    m_ie  <= bus.cp0_in[0];
                end
                if (bus.en && bus.cp0_addr == 5'd14)
                    m_epc <= bus.cp0_in;
                if (bus.exl_clr)
                    m_exl <= 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Single compare process against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_req", {31'd0, bus.req}, {31'd0, m_take()});
            chk("m_cp0_out", bus.cp0_out, m_read(bus.cp0_addr));
            chk("m_epc_out", bus.epc_out, m_epc);
            chk("m_handler", bus.handler_pc, 32'h0000_4180);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp,
                      input string nm);
        bus.cp0_addr = a;
        #1;
        chk(nm, bus.cp0_out, exp);
    endtask

    task automatic idle();
        bus.en = 1'b0; bus.cp0_addr = 5'd0; bus.cp0_in = '0;
        bus.vpc = '0; bus.bd_in = 1'b0; bus.exc_code_in = '0;
        bus.hw_int = '0; bus.exl_clr = 1'b0;
    endtask

    task automatic rand_inputs();
        int r;
        reset = ($urandom_range(0, 63) == 0);
        bus.en = ($urandom_range(0, 3) == 0);
        r = $urandom_range(0, 3);
        case (r)
            0: bus.cp0_addr = 5'd12;
            1: bus.cp0_addr = 5'd13;
            2: bus.cp0_addr = 5'd14;
            default: bus.cp0_addr = 5'($urandom);
        endcase
        bus.cp0_in = $urandom;
        bus.vpc = $urandom;
        bus.bd_in = 1'($urandom);
        r = $urandom_range(0, 7);
        case (r)
            5: begin
                case ($urandom_range(0, 4))
                    0: bus.exc_code_in = 5'd4;
                    1: bus.exc_code_in = 5'd5;
                    2: bus.exc_code_in = 5'd8;
                    3: bus.exc_code_in = 5'd10;
                    default: bus.exc_code_in = 5'd12;
                endcase
            end
            6: bus.exc_code_in = 5'($urandom);
            default: bus.exc_code_in = 5'd0;
        endcase
        bus.hw_int = {3'b000, 3'($urandom)};
        bus.exl_clr = ($urandom_range(0, 4) == 0);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        chk_on = 1'b1;

        mid();
        rd(5'd12, 32'h0, "rst_sr");
        rd(5'd13, 32'h0, "rst_cause");
        rd(5'd14, 32'h0, "rst_epc");
        chk("rst_epc_out", bus.epc_out, 32'h0);
        chk("rst_req", {31'd0, bus.req}, 32'h0);

        cyc();
        bus.hw_int = 6'b000100;
        mid();
        chk("im_masked_req", {31'd0, bus.req}, 32'h0);

        cyc();
        bus.hw_int = 6'd0;
        bus.en = 1'b1; bus.cp0_addr = 5'd12; bus.cp0_in = 32'h0000_1001;

        cyc();
        bus.en = 1'b0;
        bus.hw_int = 6'b000100; bus.vpc = 32'h0000_3010; bus.bd_in = 1'b0;
        mid();
        chk("int_req", {31'd0, bus.req}, 32'h1);

        cyc();
        mid();
        rd(5'd14, 32'h0000_3010, "int_epc");
        rd(5'd13, 32'h0000_1000, "int_cause");
        rd(5'd12, 32'h0000_1003, "int_sr");
        chk("exl_mask_req", {31'd0, bus.req}, 32'h0);

        cyc();
        bus.exl_clr = 1'b1;
        mid();
        chk("eret_cycle_req", {31'd0, bus.req}, 32'h0);

        cyc();
        bus.exl_clr = 1'b0;
        bus.en = 1'b1; bus.cp0_addr = 5'd14; bus.cp0_in = 32'h0000_3100;
        bus.vpc = 32'h0000_3014; bus.bd_in = 1'b1;
        mid();
        chk("post_eret_req", {31'd0, bus.req}, 32'h1);

        cyc();
        bus.en = 1'b0; bus.bd_in = 1'b0;
        mid();
        rd(5'd14, 32'h0000_3010, "bd_epc_drop_wr");
        rd(5'd13, 32'h8000_1000, "bd_cause");

        cyc();
        bus.hw_int = 6'd0;
        bus.exl_clr = 1'b1;
        bus.en = 1'b1; bus.cp0_addr = 5'd12; bus.cp0_in = 32'h0000_0003;

        cyc();
        bus.exl_clr = 1'b0; bus.en = 1'b0;
        bus.exc_code_in = 5'd12; bus.vpc = 32'h0000_3020;
        mid();
        rd(5'd12, 32'h0000_0001, "eret_mtc0_sr");
        chk("exc_req", {31'd0, bus.req}, 32'h1);

        cyc();
        bus.exc_code_in = 5'd10;
        mid();
        chk("exc_masked_req", {31'd0, bus.req}, 32'h0);
        rd(5'd13, 32'h0000_0030, "exc_cause");
        rd(5'd14, 32'h0000_3020, "exc_epc");

        cyc();
        bus.exc_code_in = 5'd0;
        mid();
        rd(5'd13, 32'h0000_0030, "cause_hold");

        cyc();
        bus.exl_clr = 1'b1;
        bus.en = 1'b1; bus.cp0_addr = 5'd12; bus.cp0_in = 32'h0000_1001;

        cyc();
        bus.exl_clr = 1'b0; bus.en = 1'b0;
        bus.hw_int = 6'b000100; bus.exc_code_in = 5'd4;
        bus.vpc = 32'h0000_3030;
        mid();
        chk("int_exc_req", {31'd0, bus.req}, 32'h1);

        cyc();
        bus.exc_code_in = 5'd0;
        mid();
        rd(5'd13, 32'h0000_1000, "int_beats_exc");
        rd(5'd14, 32'h0000_3030, "int_exc_epc");

        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        bus.hw_int = 6'd0;
        mid();
        rd(5'd12, 32'h0, "rst2_sr");
        rd(5'd13, 32'h0, "rst2_cause");
        rd(5'd14, 32'h0, "rst2_epc");

        for (int i = 0; i < 4000; i++) begin
            cyc();
            rand_inputs();
        end

        cyc();
        reset = 1'b0;
        idle();
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
